prio_encoder_pend: RTL and testbench

Parametrised, registered successor of the combinational 8-to-3 priority encoder. It latches N request lines into pending bits and selects one unmasked pending index, either by fixed priority or by round-robin. The index is offered on a valid/ready handshake, and the pending bit is cleared only when the index is accepted. It sits between raw event sources (keys, timers, peripheral flags) and the consumer that services them, for example the hex-display or interrupt-dispatch logic.

---
 rtl/prio_encoder_pend_if.sv | 25 ++
 rtl/prio_encoder_pend.sv | 96 +++++++++
 tb/tb_prio_encoder_pend.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_pend_if.sv
// Request/offer bundle for prio_encoder_pend: request side in master, encoder side in slave.
interface prio_encoder_pend_if #(
  parameter int unsigned N = 8
) ();
  localparam int unsigned W = $clog2(N);

  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         gs;
  logic [N-1:0] pend;

  modport master (
    output en, req, mask, out_ready,
    input  out_valid, out_idx, gs, pend
  );

  modport slave (
    input  en, req, mask, out_ready,
    output out_valid, out_idx, gs, pend
  );
endinterface

// File: rtl/prio_encoder_pend.sv
// Registered priority encoder: latches requests into pending bits and offers one
// unmasked index (fixed or round-robin) on a valid/ready handshake.
module prio_encoder_pend #(
  parameter int unsigned N    = 8,
  parameter int unsigned RR   = 0,
  parameter int unsigned EDGE = 0
) (
  input logic                clk,
  input logic                rst,
  prio_encoder_pend_if.slave bus
);
  localparam int unsigned W = $clog2(N);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t       state, state_next;
  logic [N-1:0] pend, req_q, set_vec, clr_vec, cand;
  logic [W-1:0] out_idx, idx_next, ptr, ptr_next;
  logic [W-1:0] fix_idx, rr_idx, sel_idx, scan_idx;
  logic [W:0]   scan_sum;
  logic         rr_found;

  assign cand    = pend & bus.mask;
  assign set_vec = (EDGE != 0) ? (bus.req & ~req_q) : bus.req;

  // Highest set index wins: later iterations overwrite earlier ones.
  always_comb begin
    fix_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) fix_idx = W'(i);
    end
  end

  // Scan upward from ptr+1, wrapping modulo N; first hit wins.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      scan_sum = {1'b0, ptr} + (W+1)'(k);
      scan_idx = (scan_sum >= (W+1)'(N)) ? W'(scan_sum - (W+1)'(N)) : W'(scan_sum);
      if (!rr_found && cand[scan_idx]) begin
        rr_idx   = scan_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign sel_idx = (RR != 0) ? rr_idx : fix_idx;

  always_comb begin
    state_next = state;
    idx_next   = out_idx;
    ptr_next   = ptr;
    clr_vec    = '0;
    case (state)
      IDLE: begin
        if (bus.en && (cand != '0)) begin
          idx_next   = sel_idx;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (bus.out_ready) begin
          clr_vec[out_idx] = 1'b1;
          if (RR != 0) ptr_next = out_idx;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Set is OR-ed after the clear so a same-cycle re-request keeps the bit pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= '0;
      req_q   <= '0;
      out_idx <= '0;
      ptr     <= W'(N - 1);
    end else begin
      state   <= state_next;
      pend    <= (pend & ~clr_vec) | set_vec;
      req_q   <= bus.req;
      out_idx <= idx_next;
      ptr     <= ptr_next;
    end
  end

  assign bus.out_valid = (state == OFFER);
  assign bus.out_idx   = out_idx;
  assign bus.pend      = pend;
  assign bus.gs        = bus.en & (|cand);
endmodule

// File: tb/tb_prio_encoder_pend.sv
// Bench for prio_encoder_pend: fixed/level and round-robin/edge instances against a
// cycle-level reference model, grants checked through a scoreboard queue.
module tb_prio_encoder_pend;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_encoder_pend_if #(.N(N)) bus_f ();
  prio_encoder_pend_if #(.N(N)) bus_r ();

  prio_encoder_pend #(.N(N), .RR(0), .EDGE(0)) u_fix (.clk(clk), .rst(rst), .bus(bus_f));
  prio_encoder_pend #(.N(N), .RR(1), .EDGE(1)) u_rr  (.clk(clk), .rst(rst), .bus(bus_r));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (index 0 = fixed/level, 1 = round-robin/edge).
  logic [N-1:0] m_pend  [2];
  logic [N-1:0] m_req_q [2];
  bit           m_valid [2];
  int           m_idx   [2];
  int           m_ptr   [2];
  // Model view of the current cycle, taken before the next edge is applied.
  logic [N-1:0] s_pend  [2];
  bit           s_valid [2];
  int           s_idx   [2];
  bit           s_gs    [2];

  int exp_f[$], exp_r[$];
  int got_f[$], got_r[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int pick_fixed(logic [N-1:0] c);
    for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
    return -1;
  endfunction

  // Round-robin: smallest candidate above the last grant, else smallest overall.
  function automatic int pick_rr(logic [N-1:0] c, int p);
    for (int i = p + 1; i < N; i++) if (c[i]) return i;
    for (int i = 0; i < N; i++) if (c[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = '0;
      m_req_q[d] = '0;
      m_valid[d] = 1'b0;
      m_idx[d]   = 0;
      m_ptr[d]   = N - 1;
      s_pend[d]  = '0;
      s_valid[d] = 1'b0;
      s_idx[d]   = 0;
      s_gs[d]    = 1'b0;
    end
  endtask

  task automatic model_step(int d, logic en, logic [N-1:0] req, logic [N-1:0] mask, logic rdy);
    logic [N-1:0] cand, set, clr;
    bit is_rr;
    bit is_edge;
    is_rr   = (d == 1);
    is_edge = (d == 1);
    cand       = m_pend[d] & mask;
    s_pend[d]  = m_pend[d];
    s_valid[d] = m_valid[d];
    s_idx[d]   = m_idx[d];
    s_gs[d]    = en && (cand != '0);
    set = is_edge ? (req & ~m_req_q[d]) : req;
    clr = '0;
    if (m_valid[d]) begin
      if (rdy) begin
        if (d == 0) exp_f.push_back(m_idx[d]);
        else        exp_r.push_back(m_idx[d]);
        clr[m_idx[d]] = 1'b1;
        if (is_rr) m_ptr[d] = m_idx[d];
        m_valid[d] = 1'b0;
      end
    end else if (en && cand != '0) begin
      m_idx[d]   = is_rr ? pick_rr(cand, m_ptr[d]) : pick_fixed(cand);
      m_valid[d] = 1'b1;
    end
    m_pend[d]  = (m_pend[d] & ~clr) | set;
    m_req_q[d] = req;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      else begin
        model_step(0, bus_f.en, bus_f.req, bus_f.mask, bus_f.out_ready);
        model_step(1, bus_r.en, bus_r.req, bus_r.mask, bus_r.out_ready);
      end
    end
  end

  task automatic mon(int d, string tag, logic v, logic [N-1:0] idx, logic [N-1:0] p,
                     logic g, logic rdy);
    chk({tag, "_out_valid"}, v, s_valid[d]);
    if (s_valid[d]) chk({tag, "_out_idx"}, idx, s_idx[d]);
    chk({tag, "_pend"}, p, s_pend[d]);
    chk({tag, "_gs"}, g, s_gs[d]);
    if (!rst && v === 1'b1 && rdy === 1'b1) begin
      int e;
      bit have;
      e = -1;
      if (d == 0) begin
        have = exp_f.size() > 0;
        if (have) e = exp_f.pop_front();
        got_f.push_back(int'(idx));
      end else begin
        have = exp_r.size() > 0;
        if (have) e = exp_r.pop_front();
        got_r.push_back(int'(idx));
      end
      if (!have) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_grant: got idx %0d, required no grant", tag, idx);
      end else chk({tag, "_grant"}, idx, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      mon(0, "fix", bus_f.out_valid, N'(bus_f.out_idx), bus_f.pend, bus_f.gs, bus_f.out_ready);
      mon(1, "rr",  bus_r.out_valid, N'(bus_r.out_idx), bus_r.pend, bus_r.gs, bus_r.out_ready);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(string name, int d, int a0, int a1 = -1, int a2 = -1, int a3 = -1,
                         int a4 = -1, int a5 = -1, int a6 = -1);
    int want[7];
    int n;
    int g[$];
    want = '{a0, a1, a2, a3, a4, a5, a6};
    n = 0;
    while (n < 7 && want[n] >= 0) n++;
    if (d == 0) g = got_f;
    else        g = got_r;
    chk({name, "_count"}, g.size(), n);
    for (int i = 0; i < n && i < g.size(); i++)
      chk($sformatf("%s_%0d", name, i), g[i], want[i]);
  endtask

  initial begin
    rst = 1'b1;
    bus_f.en = 1'b0; bus_f.req = '0; bus_f.mask = '1; bus_f.out_ready = 1'b0;
    bus_r.en = 1'b0; bus_r.req = '0; bus_r.mask = '1; bus_r.out_ready = 1'b0;
    cyc(2);
    chk("rst_fix_valid", bus_f.out_valid, 0);
    chk("rst_fix_pend",  bus_f.pend, 0);
    chk("rst_fix_idx",   bus_f.out_idx, 0);
    chk("rst_rr_valid",  bus_r.out_valid, 0);
    rst = 1'b0;
    cyc(2);

    // Fixed/level: 0x28 for one cycle -> 5 then 3
    got_f.delete();
    bus_f.en = 1'b1; bus_f.mask = '1; bus_f.out_ready = 1'b1;
    bus_f.req = 8'h28;
    cyc(1);
    bus_f.req = '0;
    cyc(6);
    chk("s1_pend", bus_f.pend, 0);
    chk("s1_gs", bus_f.gs, 0);
    chk_seq("s1_grant", 0, 5, 3);

    // RR/edge: pulses on 1,4,6 twice, then line 0 after 6 was last
    got_r.delete();
    bus_r.en = 1'b1; bus_r.mask = '1; bus_r.out_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      bus_r.req = 8'h52;
      cyc(1);
      bus_r.req = '0;
      cyc(8);
    end
    bus_r.req = 8'h01;
    cyc(1);
    bus_r.req = '0;
    cyc(4);
    chk_seq("s2_grant", 1, 1, 4, 6, 1, 4, 6, 0);

    // Offer stability
    got_f.delete();
    bus_f.out_ready = 1'b0;
    bus_f.req = 8'h04;
    cyc(1);
    bus_f.req = '0;
    cyc(2);
    bus_f.req = 8'h80; bus_f.mask = 8'hFB; bus_f.en = 1'b0;
    cyc(1);
    bus_f.req = '0;
    cyc(2);
    chk("s3_hold_valid", bus_f.out_valid, 1);
    chk("s3_hold_idx", bus_f.out_idx, 2);
    bus_f.out_ready = 1'b1;
    cyc(3);
    chk("s3_no_offer_en0", bus_f.out_valid, 0);
    chk("s3_pend7", bus_f.pend, 8'h80);
    bus_f.en = 1'b1;
    cyc(1);
    chk("s3_offer7_idx", bus_f.out_idx, 7);
    cyc(2);
    chk_seq("s3_grant", 0, 2, 7);
    bus_f.mask = '1;

    // Set wins over clear
    got_f.delete();
    bus_f.out_ready = 1'b0;
    bus_f.req = 8'h08;
    cyc(3);
    bus_f.out_ready = 1'b1;
    cyc(1);
    chk("s4_pend3_kept", bus_f.pend[3], 1);
    chk("s4_valid_after_grant", bus_f.out_valid, 0);
    bus_f.out_ready = 1'b0;
    cyc(1);
    chk("s4_reoffer_valid", bus_f.out_valid, 1);
    chk("s4_reoffer_idx", bus_f.out_idx, 3);
    bus_f.req = '0; bus_f.out_ready = 1'b1;
    cyc(3);
    chk("s4_pend_clear", bus_f.pend, 0);
    chk_seq("s4_grant", 0, 3, 3);

    // Masking and gs
    got_f.delete();
    bus_f.out_ready = 1'b0; bus_f.mask = 8'h01;
    bus_f.req = 8'h81;
    cyc(1);
    bus_f.req = '0;
    chk("s5_gs_on", bus_f.gs, 1);
    cyc(1);
    chk("s5_offer0_idx", bus_f.out_idx, 0);
    bus_f.out_ready = 1'b1;
    cyc(1);
    bus_f.mask = '0; bus_f.out_ready = 1'b0;
    #1;
    chk("s5_gs_off", bus_f.gs, 0);
    cyc(3);
    chk("s5_no_offer", bus_f.out_valid, 0);
    chk("s5_pend7_kept", bus_f.pend, 8'h80);
    bus_f.mask = '1; bus_f.out_ready = 1'b1;
    cyc(4);
    chk_seq("s5_grant", 0, 0, 7);

    // Async reset mid-offer, edge-mode recapture of a held request
    got_r.delete();
    bus_r.out_ready = 1'b0;
    bus_r.req = 8'h10;
    cyc(1);
    bus_r.req = '0;
    cyc(2);
    chk("s6_offer4_idx", bus_r.out_idx, 4);
    #2;
    rst = 1'b1;
    bus_r.req = 8'h04;
    #1;
    chk("s6_async_valid", bus_r.out_valid, 0);
    chk("s6_async_pend", bus_r.pend, 0);
    chk("s6_async_idx", bus_r.out_idx, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("s6_reoffer_valid", bus_r.out_valid, 1);
    chk("s6_reoffer_idx", bus_r.out_idx, 2);
    bus_r.out_ready = 1'b1; bus_r.req = '0;
    cyc(3);
    chk_seq("s6_grant", 1, 2);

    // Randomised traffic with occasional asynchronous resets
    for (int c = 0; c < 600; c++) begin
      bus_f.req       = N'($urandom) & N'($urandom) & N'($urandom);
      bus_r.req       = N'($urandom) & N'($urandom);
      bus_f.mask      = ($urandom_range(0, 4) == 0) ? N'($urandom) : '1;
      bus_r.mask      = ($urandom_range(0, 4) == 0) ? N'($urandom) : '1;
      bus_f.en        = ($urandom_range(0, 7) != 0);
      bus_r.en        = ($urandom_range(0, 7) != 0);
      bus_f.out_ready = ($urandom_range(0, 2) != 0);
      bus_r.out_ready = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end else cyc(1);
    end

    bus_f.en = 1'b1; bus_f.req = '0; bus_f.mask = '1; bus_f.out_ready = 1'b1;
    bus_r.en = 1'b1; bus_r.req = '0; bus_r.mask = '1; bus_r.out_ready = 1'b1;
    cyc(40);
    chk("drain_fix_pend", bus_f.pend, 0);
    chk("drain_rr_pend", bus_r.pend, 0);
    chk("drain_fix_queue", exp_f.size(), 0);
    chk("drain_rr_queue", exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
